// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared types and helpers for the memory responder.
//   - state_t        : responder FSM states (IDLE, WAIT, RESP)
//   - BYTES_PER_WORD : byte lanes per 32-bit word
//   - word_index()   : byte address -> word index
//   - is_fault()     : misaligned or out-of-range test for a byte address
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  // A word access faults when it is not word aligned or when its word
  // index falls at or beyond the end of the array.
  function automatic logic is_fault(input logic [31:0] addr, input int depth);
    logic [31:0] idx;
    idx = {2'b00, word_index(addr)};
    return (addr[1:0] != 2'b00) || (idx >= $unsigned(depth));
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram
//   DEPTH_WORDS x 32 word store built from four independent byte-lane arrays.
//   Ports:
//     clk    : clock
//     en     : access enable; qualifies both the write and the read
//     byteWe : per-lane write enables (lane i = wdata[8i+7:8i])
//     addr   : word index
//     wdata  : write data
//     rdata  : registered read data (old contents on a same-cycle write)
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        byteWe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  // One narrow array per lane keeps each lane a plain single-port memory.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH_WORDS];
      logic [7:0] laneRdReg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (byteWe[gi]) begin
            laneMem[addr] <= wdata[8*gi +: 8];
          end
          laneRdReg <= laneMem[addr];
        end
      end

      assign rdata[8*gi +: 8] = laneRdReg;
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Handshaked memory target for the multicycle CPU memory port. Accepts one
//   word request at a time, inserts WAIT_STATES wait cycles, then commits the
//   access to the internal array and returns a one-cycle Ready strobe.
//   Ports:
//     Clk     : clock
//     Reset   : asynchronous active-low reset
//     Req     : request valid, sampled only in IDLE
//     Wr      : 1 = write, 0 = read
//     Address : byte address (word index = Address[31:2])
//     Datain  : write data
//     ByteEn  : write byte lanes (ignored on reads)
//     Ready   : one-cycle response strobe
//     Dataout : read data, valid with Ready; holds its last value otherwise
//     Error   : access fault, only ever high together with Ready
//     Busy    : high whenever the responder is not IDLE
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
  input  logic [3:0]  ByteEn,
  output logic        Ready,
  output logic [31:0] Dataout,
  output logic        Error,
  output logic        Busy
);

  localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      stateReg;
  logic [3:0]  countReg;
  logic        wrReg;
  logic [31:0] addrReg;
  logic [31:0] dataReg;
  logic [3:0]  byteEnReg;
  logic        readyReg;
  logic        errorReg;
  logic        busyReg;
  logic        readOkReg;
  logic [31:0] holdReg;

  // The access presented to the array: straight from the inputs when
  // committing out of IDLE (zero wait states), else from the holding regs.
  logic        accWr;
  logic [31:0] accAddr;
  logic [31:0] accData;
  logic [3:0]  accByteEn;
  logic        accFault;
  logic [29:0] accIdx;
  logic        commit;
  logic [3:0]  ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0] ramRdData;
  logic [31:0] respData;

  always_comb begin
    accWr     = wrReg;
    accAddr   = addrReg;
    accData   = dataReg;
    accByteEn = byteEnReg;
    if (stateReg == IDLE) begin
      accWr     = Wr;
      accAddr   = Address;
      accData   = Datain;
      accByteEn = ByteEn;
    end
  end

  assign accFault = is_fault(accAddr, DEPTH_WORDS);
  assign accIdx   = word_index(accAddr);
  assign ramAddr  = accIdx[ADDR_W-1:0];

  // Commit happens on the edge that enters RESP.
  assign commit = ((stateReg == IDLE) && Req && (WAIT_STATES == 0)) ||
                  ((stateReg == WAIT) && (countReg == 4'd0));

  assign ramWe = (commit && accWr && !accFault) ? accByteEn : 4'b0000;

  mem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) uRam (
    .clk    (Clk),
    .en     (commit),
    .byteWe (ramWe),
    .addr   (ramAddr),
    .wdata  (accData),
    .rdata  (ramRdData)
  );

  // The array read data only exists during RESP, so the visible value is
  // selected there and copied into holdReg for the cycles that follow.
  assign respData = readOkReg ? ramRdData : 32'h0;
  assign Dataout  = (stateReg == RESP) ? respData : holdReg;
  assign Ready    = readyReg;
  assign Error    = errorReg;
  assign Busy     = busyReg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg  <= IDLE;
      countReg  <= 4'd0;
      wrReg     <= 1'b0;
      addrReg   <= 32'h0;
      dataReg   <= 32'h0;
      byteEnReg <= 4'b0000;
      readyReg  <= 1'b0;
      errorReg  <= 1'b0;
      busyReg   <= 1'b0;
      readOkReg <= 1'b0;
      holdReg   <= 32'h0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (Req) begin
            wrReg     <= Wr;
            addrReg   <= Address;
            dataReg   <= Datain;
            byteEnReg <= ByteEn;
            busyReg   <= 1'b1;
            if (WAIT_STATES > 0) begin
              countReg <= WAIT_LOAD;
              stateReg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (countReg != 4'd0) begin
            countReg <= countReg - 4'd1;
          end
        end
        RESP: begin
          stateReg  <= IDLE;
          readyReg  <= 1'b0;
          errorReg  <= 1'b0;
          busyReg   <= 1'b0;
          readOkReg <= 1'b0;
          holdReg   <= respData;
        end
        default: begin
          stateReg <= IDLE;
          readyReg <= 1'b0;
          errorReg <= 1'b0;
          busyReg  <= 1'b0;
        end
      endcase

      if (commit) begin
        stateReg  <= RESP;
        readyReg  <= 1'b1;
        errorReg  <= accFault;
        readOkReg <= !accWr && !accFault;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with zero wait states (index 0) and
// one with two wait states (index 1), checked against a word-array model.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int WS1   = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqS   [2];
  logic        wrS    [2];
  logic [31:0] addrS  [2];
  logic [31:0] dinS   [2];
  logic [3:0]  beS    [2];
  logic        readyS [2];
  logic [31:0] doutS  [2];
  logic        errS   [2];
  logic        busyS  [2];

  logic [31:0] model [2][DEPTH];
  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rstN), .Req(reqS[0]), .Wr(wrS[0]), .Address(addrS[0]),
    .Datain(dinS[0]), .ByteEn(beS[0]), .Ready(readyS[0]), .Dataout(doutS[0]),
    .Error(errS[0]), .Busy(busyS[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut2 (
    .Clk(clk), .Reset(rstN), .Req(reqS[1]), .Wr(wrS[1]), .Address(addrS[1]),
    .Datain(dinS[1]), .ByteEn(beS[1]), .Ready(readyS[1]), .Dataout(doutS[1]),
    .Error(errS[1]), .Busy(busyS[1]));

  // Reference: a fault is a non-multiple-of-4 address or a word beyond the
  // array; a good write merges enabled bytes, a good read returns the word.
  task automatic modelRef(input int s, input logic wr, input logic [31:0] addr,
                          input logic [31:0] din, input logic [3:0] be,
                          output logic [31:0] expDout, output logic expErr);
    int unsigned w;
    w = addr / 4;
    if ((addr % 4 != 0) || (w >= DEPTH)) begin
      expDout = 32'h0;
      expErr  = 1'b1;
    end else begin
      expErr = 1'b0;
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[s][w][8*b +: 8] = din[8*b +: 8];
        end
        expDout = 32'h0;
      end else begin
        expDout = model[s][w];
      end
    end
  endtask

  // Issue one request, scramble the inputs after capture, wait (bounded) for
  // Ready, and return in the IDLE cycle after the response.
  task automatic doAccess(input int s, input logic wr, input logic [31:0] addr,
                          input logic [31:0] din, input logic [3:0] be,
                          output logic [31:0] dout, output logic err, output int lat);
    @(negedge clk);
    reqS[s] = 1'b1; wrS[s] = wr; addrS[s] = addr; dinS[s] = din; beS[s] = be;
    @(posedge clk); #1;
    reqS[s] = 1'b0; wrS[s] = 1'($urandom); addrS[s] = $urandom; dinS[s] = $urandom;
    beS[s] = 4'($urandom);
    lat = 0;
    while (!readyS[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    dout = doutS[s];
    err  = errS[s];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      reqS[s] = 1'b0; wrS[s] = 1'b0; addrS[s] = 32'h0; dinS[s] = 32'h0; beS[s] = 4'h0;
    end
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checkCount++;
      if ({readyS[s], errS[s], busyS[s]} !== 3'b000) $display("FAIL reset_flags[%0d] got %b want 000", s, {readyS[s], errS[s], busyS[s]});
      else passCount++;
      checkCount++;
      if (doutS[s] !== 32'h0) $display("FAIL reset_dout[%0d] got %h want 00000000", s, doutS[s]);
      else passCount++;
    end
    @(negedge clk) rstN = 1'b1;
  endtask

  task automatic init_array();
    logic [31:0] d, ed; logic e, ee; int lat;
    for (int i = 0; i < DEPTH; i++) begin
      modelRef(1, 1'b1, 32'(i * 4), 32'h0, 4'hF, ed, ee);
      doAccess(1, 1'b1, 32'(i * 4), 32'h0, 4'hF, d, e, lat);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    doAccess(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
    model[1][4] = 32'hDEADBEEF;
    checkCount++;
    if (lat !== WS1) $display("FAIL wr_latency got %0d want %0d", lat, WS1); else passCount++;
    checkCount++;
    if (e !== 1'b0) $display("FAIL wr_error got %b want 0", e); else passCount++;
    doAccess(1, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (lat !== WS1) $display("FAIL rd_latency got %0d want %0d", lat, WS1); else passCount++;
    checkCount++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL rd_data got %h/%b want deadbeef/0", d, e); else passCount++;
    checkCount++;
    if (doutS[1] !== 32'hDEADBEEF || errS[1] !== 1'b0) $display("FAIL dout_hold got %h/%b want deadbeef/0", doutS[1], errS[1]);
    else passCount++;
  endtask

  task automatic test_byte_mask();
    logic [31:0] d; logic e; int lat;
    doAccess(1, 1'b1, 32'h20, 32'h11223344, 4'hF, d, e, lat);
    doAccess(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, d, e, lat);
    doAccess(1, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    model[1][8] = 32'h11BB33DD;
    checkCount++;
    if (d !== 32'h11BB33DD) $display("FAIL byte_mask got %h want 11bb33dd", d); else passCount++;
  endtask

  task automatic test_faults();
    logic [31:0] d, ed; logic e, ee; int lat;
    doAccess(1, 1'b0, 32'h13, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (d !== 32'h0 || e !== 1'b1) $display("FAIL misaligned got %h/%b want 00000000/1", d, e); else passCount++;
    doAccess(1, 1'b1, 32'(4 * DEPTH), 32'h5A5A5A5A, 4'hF, d, e, lat);
    checkCount++;
    if (d !== 32'h0 || e !== 1'b1) $display("FAIL out_of_range got %h/%b want 00000000/1", d, e); else passCount++;
    modelRef(1, 1'b0, 32'h0, 32'h0, 4'h0, ed, ee);
    doAccess(1, 1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (d !== ed || e !== ee) $display("FAIL word0_intact got %h/%b want %h/%b", d, e, ed, ee); else passCount++;
  endtask

  task automatic test_random();
    logic [31:0] a, din, d, ed; logic [3:0] be; logic wr, e, ee; int lat, r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (r == 7) a = a | 32'($urandom_range(1, 3));
      else if (r >= 8) a = 32'(DEPTH + $urandom_range(0, 1000)) * 4 + 32'($urandom_range(0, 3));
      wr = 1'($urandom); din = $urandom; be = 4'($urandom);
      modelRef(1, wr, a, din, be, ed, ee);
      doAccess(1, wr, a, din, be, d, e, lat);
      checkCount++;
      if (d !== ed || e !== ee || lat !== WS1)
        $display("FAIL random[%0d] addr=%h wr=%b got %h/%b/lat%0d want %h/%b/lat%0d", i, a, wr, d, e, lat, ed, ee, WS1);
      else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] din, d; logic e; int lat;
    din = $urandom;
    doAccess(1, 1'b1, 32'h84, din, 4'hF, d, e, lat);
    model[1][33] = din;
    doAccess(1, 1'b0, 32'h84, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (d !== din || e !== 1'b0) $display("FAIL raw got %h/%b want %h/0", d, e, din); else passCount++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] d; logic e; int lat;
    @(negedge clk);
    reqS[0] = 1'b1; wrS[0] = 1'b1; addrS[0] = 32'h8; dinS[0] = 32'hCAFEF00D; beS[0] = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checkCount++;
      if (readyS[0] !== 1'(k % 2 == 0) || busyS[0] !== 1'(k % 2 == 0))
        $display("FAIL zw_cycle[%0d] got rdy=%b busy=%b want %b", k, readyS[0], busyS[0], 1'(k % 2 == 0));
      else passCount++;
    end
    @(negedge clk) reqS[0] = 1'b0;
    @(posedge clk); #1;
    doAccess(0, 1'b0, 32'h8, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (d !== 32'hCAFEF00D || e !== 1'b0 || lat !== 0)
      $display("FAIL zw_read got %h/%b/lat%0d want cafef00d/0/lat0", d, e, lat);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed; logic e, ee; int lat;
    @(negedge clk);
    reqS[1] = 1'b1; wrS[1] = 1'b1; addrS[1] = 32'h40; dinS[1] = 32'h12345678; beS[1] = 4'hF;
    @(posedge clk); #1;
    reqS[1] = 1'b0;
    @(posedge clk); #2;
    checkCount++;
    if (busyS[1] !== 1'b1) $display("FAIL mid_busy got %b want 1", busyS[1]); else passCount++;
    rstN = 1'b0;
    #1;
    checkCount++;
    if ({readyS[1], busyS[1], errS[1]} !== 3'b000)
      $display("FAIL async_reset got %b want 000", {readyS[1], busyS[1], errS[1]});
    else passCount++;
    @(negedge clk) rstN = 1'b1;
    modelRef(1, 1'b0, 32'h40, 32'h0, 4'h0, ed, ee);
    doAccess(1, 1'b0, 32'h40, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (d !== 32'h0 || d !== ed || e !== 1'b0) $display("FAIL dropped_write got %h/%b want 00000000/0", d, e); else passCount++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d, ed, ed2; logic e, ee, ee2; int lat, extra;
    modelRef(1, 1'b0, 32'h24, 32'h0, 4'h0, ed, ee);
    @(negedge clk);
    reqS[1] = 1'b1; wrS[1] = 1'b0; addrS[1] = 32'h24; dinS[1] = 32'h0; beS[1] = 4'h0;
    @(posedge clk); #1;
    // Keep Req up with a different write request while the first is busy.
    wrS[1] = 1'b1; addrS[1] = 32'h28; dinS[1] = $urandom; beS[1] = 4'hF;
    lat = 0;
    while (!readyS[1] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    reqS[1] = 1'b0;
    d = doutS[1]; e = errS[1];
    checkCount++;
    if (d !== ed || e !== ee || lat !== WS1)
      $display("FAIL busy_capture got %h/%b/lat%0d want %h/%b/lat%0d", d, e, lat, ed, ee, WS1);
    else passCount++;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (readyS[1]) extra++;
    end
    checkCount++;
    if (extra !== 0) $display("FAIL busy_extra_ready got %0d want 0", extra); else passCount++;
    modelRef(1, 1'b0, 32'h28, 32'h0, 4'h0, ed2, ee2);
    doAccess(1, 1'b0, 32'h28, 32'h0, 4'h0, d, e, lat);
    checkCount++;
    if (d !== ed2 || e !== ee2) $display("FAIL busy_no_write got %h/%b want %h/%b", d, e, ed2, ee2); else passCount++;
  endtask

  initial begin
    test_reset();
    init_array();
    test_write_read();
    test_byte_mask();
    test_faults();
    test_random();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid();
    test_busy_ignore();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
